// File: rtl/lsu_dbus_pkg.sv
// rtl/lsu_dbus_pkg.sv - funct3 codes, FSM encodings and access-size helpers for lsu_dbus
package lsu_dbus_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ST_ERR is only reachable when the misalignment check is built in
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUS  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    localparam int TO_CNT_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    // Reserved encodings fall through to a word access
    function automatic acc_size_e access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (access_size(funct3))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte strobes, store lane replication and load extraction
module lsu_align
    import lsu_dbus_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    acc_size_e   size;
    logic        sign_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign size      = access_size(funct3);
    assign sign_ext  = ~funct3[2];
    assign byte_lane = 8'(rdata >> {addr_lo, 3'b000});
    assign half_lane = 16'(rdata >> {addr_lo[1], 4'b0000});

    always_comb begin
        bus_sel   = 4'b1111;
        bus_wdata = wdata;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                bus_sel   = 4'b0001 << addr_lo;
                bus_wdata = {4{wdata[7:0]}};
                load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                bus_sel   = 4'b0011 << {addr_lo[1], 1'b0};
                bus_wdata = {2{wdata[15:0]}};
                load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
            end
            default: begin
                bus_sel   = 4'b1111;
                bus_wdata = wdata;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dbus.sv
// rtl/lsu_dbus.sv - load/store unit data-bus FSM; optional LSU_MISALIGN_CHK_EN misalignment trap
module lsu_dbus
    import lsu_dbus_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        hold_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        err_o
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    logic [1:0]          state;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [2:0]          funct3_q;
    logic [4:0]          rd_q;
    logic [TO_CNT_W-1:0] cnt;
    logic                err_q;

    logic        in_idle;
    logic        in_bus;
    logic        in_done;
    logic        in_err;
    logic        wb_en;
    logic [3:0]  sel;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    lsu_align u_align (
        .funct3    (funct3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (rdata_q),
        .bus_sel   (sel),
        .bus_wdata (lane_wdata),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        we_q     <= we_i;
                        addr_q   <= addr_i;
                        wdata_q  <= wdata_i;
                        funct3_q <= funct3_i;
                        rd_q     <= rd_i;
                        cnt      <= '0;
`ifdef LSU_MISALIGN_CHK_EN
                        if (is_misaligned(funct3_i, addr_i[1:0])) begin
                            state <= ST_ERR;
                            err_q <= 1'b1;
                        end else begin
                            state <= ST_BUS;
                        end
`else
                        state <= ST_BUS;
`endif
                    end
                end
                ST_BUS: begin
                    // An ack arriving on the last allowed cycle still completes the access
                    if (bus_ack_i) begin
                        rdata_q <= bus_rdata_i;
                        state   <= ST_DONE;
                    end else if (cnt == TO_LAST) begin
                        state <= ST_IDLE;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_idle = (state == ST_IDLE);
    assign in_bus  = (state == ST_BUS);
    assign in_done = (state == ST_DONE);
    assign in_err  = (state == ST_ERR);

    // Bus outputs are gated by state so an async reset clears them at once
    assign bus_req_o   = in_bus;
    assign bus_we_o    = in_bus & we_q;
    assign bus_addr_o  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_wdata_o = in_bus ? lane_wdata : 32'h0;
    assign bus_sel_o   = in_bus ? sel : 4'b0000;

    assign wb_en       = in_done & ~we_q & (rd_q != 5'd0);
    assign reg_we_o    = wb_en;
    assign reg_waddr_o = wb_en ? rd_q : 5'd0;
    assign reg_wdata_o = wb_en ? load_data : 32'h0;

    assign hold_o = rst & (in_bus | in_err | (in_idle & req_i));
    assign err_o  = err_q;

endmodule

// File: tb/tb_lsu_dbus.sv
// tb/tb_lsu_dbus.sv - randomized self-checking bench for lsu_dbus against a behavioural model
module tb_lsu_dbus;

    localparam int TO = 4;

`ifdef LSU_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        hold_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        err_o;

    int n_checks = 0;
    int n_pass   = 0;

    lsu_dbus #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .funct3_i    (funct3_i),
        .rd_i        (rd_i),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_sel_o   (bus_sel_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .hold_o      (hold_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int acc_bytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % acc_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] exp_sel(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (acc_bytes(f3) == 1) return 32'(1 << off);
        if (acc_bytes(f3) == 2) return 32'(3 << (off - off % 2));
        return 32'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (acc_bytes(f3) == 1) return (w % 256) * 32'h0101_0101;
        if (acc_bytes(f3) == 2) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        int off;
        off = int'(a % 4);
        if (acc_bytes(f3) == 1) begin
            v = (r >> (8 * off)) % 256;
            if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (acc_bytes(f3) == 2) begin
            v = (r >> (8 * (off - off % 2))) % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return r;
    endfunction

    // Issue one access starting in an IDLE cycle (called #1 after a rising edge)
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [2:0] f3, input logic [4:0] rd, input int delay,
                             input logic [31:0] rdata);
        bit done;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; funct3_i = f3; rd_i = rd;
        bus_ack_i = 1'b0;
        @(negedge clk);
        check("c0_hold", hold_o, 1);
        check("c0_bus_req", bus_req_o, 0);
        check("c0_err", err_o, 0);
        @(posedge clk); #1;
        if (MIS_EN && is_mis(f3, addr)) begin
            @(negedge clk);
            check("mis_err", err_o, 1);
            check("mis_bus_req", bus_req_o, 0);
            check("mis_hold", hold_o, 1);
            check("mis_reg_we", reg_we_o, 0);
            @(posedge clk); #1;
            req_i = 1'b0;
            return;
        end
        done = 0;
        for (int k = 0; k < TO; k++) begin
            bus_ack_i   = (k == delay);
            bus_rdata_i = (k == delay) ? rdata : $urandom;
            @(negedge clk);
            check("bus_req", bus_req_o, 1);
            check("bus_hold", hold_o, 1);
            check("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
            check("bus_we", bus_we_o, we);
            check("bus_sel", bus_sel_o, exp_sel(f3, addr));
            if (we) check("bus_wdata", bus_wdata_o, exp_wdata(f3, wd));
            check("bus_reg_we", reg_we_o, 0);
            check("bus_err", err_o, 0);
            @(posedge clk); #1;
            if (k == delay) begin
                done = 1;
                break;
            end
        end
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
        if (done) begin
            @(negedge clk);
            check("done_reg_we", reg_we_o, (!we && rd != 5'd0));
            if (!we && rd != 5'd0) begin
                check("done_waddr", reg_waddr_o, rd);
                check("done_wdata", reg_wdata_o, exp_load(f3, addr, rdata));
            end
            check("done_hold", hold_o, 0);
            check("done_bus_req", bus_req_o, 0);
            check("done_err", err_o, 0);
            @(posedge clk); #1;
            req_i = 1'b0;
        end else begin
            req_i = 1'b0;
            @(negedge clk);
            check("to_err", err_o, 1);
            check("to_bus_req", bus_req_o, 0);
            check("to_reg_we", reg_we_o, 0);
            check("to_hold", hold_o, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycle();
        req_i = 1'b0;
        bus_ack_i = 1'($urandom);
        bus_rdata_i = $urandom;
        @(negedge clk);
        check("idle_hold", hold_o, 0);
        check("idle_bus_req", bus_req_o, 0);
        check("idle_reg_we", reg_we_o, 0);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] f3;
        logic       we;
        logic [2:0] f3_list [8];
        f3_list = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        rst = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        funct3_i = '0; rd_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        @(negedge clk);
        check("rst_bus_req", bus_req_o, 0);
        check("rst_bus_addr", bus_addr_o, 0);
        check("rst_hold", hold_o, 0);
        check("rst_reg_we", reg_we_o, 0);
        check("rst_err", err_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        do_access(1'b0, 32'h100, 32'h0, 3'd2, 5'd5, 0, 32'hDEADBEEF);
        do_access(1'b0, 32'h103, 32'h0, 3'd0, 5'd6, 1, 32'h80FFFFFF);
        do_access(1'b0, 32'h103, 32'h0, 3'd4, 5'd7, 0, 32'h80FFFFFF);
        do_access(1'b0, 32'h102, 32'h0, 3'd5, 5'd8, 2, 32'hABCD0000);
        do_access(1'b1, 32'h202, 32'h1234, 3'd1, 5'd9, 0, 32'h0);
        do_access(1'b0, 32'h104, 32'h0, 3'd2, 5'd0, 0, 32'h55AA55AA);
        do_access(1'b0, 32'h108, 32'h0, 3'd2, 5'd3, 99, 32'h0);
        idle_cycle();
        do_access(1'b0, 32'h101, 32'h0, 3'd2, 5'd4, 0, 32'h11223344);
        idle_cycle();

        // Reset mid-BUS aborts the access; a late ack must not write back
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h300; funct3_i = 3'd2; rd_i = 5'd7;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstbus_pre_req", bus_req_o, 1);
        #2 rst = 1'b0;
        #1;
        check("rstbus_req", bus_req_o, 0);
        check("rstbus_hold", hold_o, 0);
        req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
            @(negedge clk);
            check("rstbus_late_reg_we", reg_we_o, 0);
            check("rstbus_late_req", bus_req_o, 0);
            @(posedge clk); #1;
        end
        bus_ack_i = 1'b0;

        for (int t = 0; t < 60; t++) begin
            we = 1'($urandom);
            f3 = we ? 3'($urandom_range(0, 2)) : f3_list[$urandom_range(0, 7)];
            do_access(we, $urandom, $urandom, f3, 5'($urandom), $urandom_range(0, 5), $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
